// File: rtl/car_sprite_reader.sv
// -----------------------------------------------------------------------------
// car_sprite_reader
//
// Consumer end of a lane pixel bus. For each pixel it computes the car sprite
// ROM address, picks up the palette index the ROM returns, resolves it through
// a 16-entry writable palette, and tracks car/player overlap on opaque texels.
// The result for a pixel presented before edge N appears after edge N+2.
// There are no stalls: one pixel is accepted on every clock.
//
// Ports:
//   Clk          system clock, all state on the rising edge
//   ResetN       asynchronous active-low reset
//   CarPixel     lane reports a car covering the current pixel
//   PlayerPixel  player sprite covers the current pixel
//   Tile         car sprite tile index (0..15)
//   PixelX       column within the car sprite
//   PixelY       row within the car sprite
//   FrameStart   one-clock pulse at the start of each frame
//   RomAddr      sprite ROM address (registered)
//   RomData      palette index returned by the ROM for RomAddr
//   PalWe        palette write strobe
//   PalIdx       palette write index
//   PalRgb       palette write data {R4,G4,B4}
//   CarVisible   opaque car texel in this output slot
//   CarRgb       colour of that texel, 0 when not visible
//   Hit          sticky collision flag
//   HitAck       acknowledge that clears Hit
//   LastOverlap  opaque overlap pixel count of the previous frame
// -----------------------------------------------------------------------------
module car_sprite_reader #(
  parameter int SpriteW = 48,
  parameter int SpriteH = 26,
  parameter int AddrW   = 15
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             CarPixel,
  input  logic             PlayerPixel,
  input  logic [3:0]       Tile,
  input  logic [5:0]       PixelX,
  input  logic [4:0]       PixelY,
  input  logic             FrameStart,
  output logic [AddrW-1:0] RomAddr,
  input  logic [3:0]       RomData,
  input  logic             PalWe,
  input  logic [3:0]       PalIdx,
  input  logic [11:0]      PalRgb,
  output logic             CarVisible,
  output logic [11:0]      CarRgb,
  output logic             Hit,
  input  logic             HitAck,
  output logic [7:0]       LastOverlap
);

  localparam int TileSize = SpriteW * SpriteH;

  logic             inRange;
  logic [AddrW-1:0] addrCalc;

  logic             v1;
  logic             p1;
  logic             v2;
  logic             p2;
  logic [3:0]       idx2;
  logic             opaque2;
  logic             ov2;

  logic [11:0]      palMem [16];
  logic [7:0]       ovCount;
  logic [7:0]       ovCountInc;

  // A pixel only counts as a car pixel when it also lies inside the sprite
  // rectangle; out-of-range coordinates would otherwise alias into the
  // neighbouring tile.
  assign inRange = CarPixel && (int'(PixelX) < SpriteW) && (int'(PixelY) < SpriteH);

  // All operands are widened to AddrW before multiplying so the full
  // tile offset is kept (the largest address still fits in AddrW bits).
  assign addrCalc = AddrW'(Tile) * AddrW'(TileSize)
                  + AddrW'(PixelY) * AddrW'(SpriteW)
                  + AddrW'(PixelX);

  // Index 0 is the transparent colour regardless of what pal[0] holds.
  assign opaque2 = v2 && (idx2 != 4'd0);
  assign ov2     = opaque2 && p2;

  assign ovCountInc = (ovCount == 8'hFF) ? 8'hFF : ovCount + 8'd1;

  // Stage 1: register the ROM address and the validity/player tags. Invalid
  // pixels park the ROM on address 0.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      v1      <= 1'b0;
      p1      <= 1'b0;
      RomAddr <= '0;
    end else begin
      v1      <= inRange;
      p1      <= PlayerPixel;
      RomAddr <= inRange ? addrCalc : '0;
    end
  end

  // Stage 2: the ROM answers within the cycle after RomAddr, so its index is
  // captured alongside the delayed tags.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      v2   <= 1'b0;
      p2   <= 1'b0;
      idx2 <= 4'd0;
    end else begin
      v2   <= v1;
      p2   <= p1;
      idx2 <= RomData;
    end
  end

  // Palette storage. A write landing on the same edge that stage 3 reads the
  // same entry is not forwarded: stage 3 sees the old colour.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 16; i++) begin
        palMem[i] <= 12'h000;
      end
    end else if (PalWe) begin
      palMem[PalIdx] <= PalRgb;
    end
  end

  // Stage 3: colour resolution, forced to black for transparent texels.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      CarVisible <= 1'b0;
      CarRgb     <= 12'h000;
    end else begin
      CarVisible <= opaque2;
      CarRgb     <= opaque2 ? palMem[idx2] : 12'h000;
    end
  end

  // Sticky collision flag; a fresh overlap beats a simultaneous acknowledge
  // so the game FSM never loses a collision.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Hit <= 1'b0;
    end else if (ov2) begin
      Hit <= 1'b1;
    end else if (HitAck) begin
      Hit <= 1'b0;
    end
  end

  // Per-frame overlap counter. On a frame boundary the running count is
  // snapshotted; an overlap on that very edge belongs to the new frame, so it
  // seeds the counter with 1 instead of joining the snapshot.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ovCount     <= 8'd0;
      LastOverlap <= 8'd0;
    end else if (FrameStart) begin
      LastOverlap <= ovCount;
      ovCount     <= ov2 ? 8'd1 : 8'd0;
    end else if (ov2) begin
      ovCount     <= ovCountInc;
    end
  end

endmodule

// File: tb/tb_car_sprite_reader.sv
// -----------------------------------------------------------------------------
// tb_car_sprite_reader
//
// Directed testbench for car_sprite_reader. Inputs change on the falling edge
// and outputs are sampled on the falling edge, so every value observed at the
// k-th falling edge after driving a pixel reflects k rising edges.
// The sprite ROM is modelled as a memory read combinationally from RomAddr.
// -----------------------------------------------------------------------------
module tb_car_sprite_reader;

  logic        Clk;
  logic        ResetN;
  logic        CarPixel;
  logic        PlayerPixel;
  logic [3:0]  Tile;
  logic [5:0]  PixelX;
  logic [4:0]  PixelY;
  logic        FrameStart;
  logic [14:0] RomAddr;
  logic [3:0]  RomData;
  logic        PalWe;
  logic [3:0]  PalIdx;
  logic [11:0] PalRgb;
  logic        CarVisible;
  logic [11:0] CarRgb;
  logic        Hit;
  logic        HitAck;
  logic [7:0]  LastOverlap;

  logic [3:0]  romMem [0:32767];

  int checks;
  int failures;

  car_sprite_reader #(
    .SpriteW(48),
    .SpriteH(26),
    .AddrW  (15)
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .CarPixel   (CarPixel),
    .PlayerPixel(PlayerPixel),
    .Tile       (Tile),
    .PixelX     (PixelX),
    .PixelY     (PixelY),
    .FrameStart (FrameStart),
    .RomAddr    (RomAddr),
    .RomData    (RomData),
    .PalWe      (PalWe),
    .PalIdx     (PalIdx),
    .PalRgb     (PalRgb),
    .CarVisible (CarVisible),
    .CarRgb     (CarRgb),
    .Hit        (Hit),
    .HitAck     (HitAck),
    .LastOverlap(LastOverlap)
  );

  assign RomData = romMem[RomAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idleInputs();
    CarPixel    = 1'b0;
    PlayerPixel = 1'b0;
    Tile        = 4'd0;
    PixelX      = 6'd0;
    PixelY      = 5'd0;
    FrameStart  = 1'b0;
    PalWe       = 1'b0;
    PalIdx      = 4'd0;
    PalRgb      = 12'h000;
    HitAck      = 1'b0;
  endtask

  task automatic setPixel(input logic car, input logic player, input logic [3:0] t,
                          input logic [5:0] x, input logic [4:0] y);
    CarPixel    = car;
    PlayerPixel = player;
    Tile        = t;
    PixelX      = x;
    PixelY      = y;
  endtask

  task automatic writePal(input logic [3:0] idx, input logic [11:0] rgb);
    PalWe  = 1'b1;
    PalIdx = idx;
    PalRgb = rgb;
    @(negedge Clk);
    PalWe  = 1'b0;
  endtask

  // Reset values of every output, plus RomAddr held at zero while in reset.
  task automatic test_reset();
    ResetN = 1'b0;
    idleInputs();
    repeat (2) @(negedge Clk);
    if (RomAddr !== 15'd0) begin
      failures++;
      $display("[TB] FAIL reset_romaddr got=%0d exp=0", RomAddr);
    end
    checks++;
    if (CarVisible !== 1'b0 || CarRgb !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_pixel got vis=%b rgb=%h exp vis=0 rgb=000", CarVisible, CarRgb);
    end
    checks++;
    if (Hit !== 1'b0 || LastOverlap !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_hit got hit=%b last=%0d exp hit=0 last=0", Hit, LastOverlap);
    end
    checks++;
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  // Address 2*1248 + 4*48 + 3 = 2691, index 5 -> F80 three edges later.
  task automatic test_basic_pixel();
    writePal(4'd5, 12'hF80);
    setPixel(1'b1, 1'b0, 4'd2, 6'd3, 5'd4);
    @(negedge Clk);
    idleInputs();
    if (RomAddr !== 15'd2691) begin
      failures++;
      $display("[TB] FAIL basic_romaddr got=%0d exp=2691", RomAddr);
    end
    checks++;
    @(negedge Clk);
    if (CarVisible !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_early got vis=%b exp vis=0", CarVisible);
    end
    checks++;
    @(negedge Clk);
    if (CarVisible !== 1'b1 || CarRgb !== 12'hF80) begin
      failures++;
      $display("[TB] FAIL basic_visible got vis=%b rgb=%h exp vis=1 rgb=F80", CarVisible, CarRgb);
    end
    checks++;
    @(negedge Clk);
    if (CarVisible !== 1'b0 || CarRgb !== 12'h000) begin
      failures++;
      $display("[TB] FAIL basic_after got vis=%b rgb=%h exp vis=0 rgb=000", CarVisible, CarRgb);
    end
    checks++;
  endtask

  // Transparent index, out-of-range X and Y, and the largest legal address.
  task automatic test_range_and_transparency();
    // Tile 1 origin -> address 1248 which holds index 0 (transparent).
    setPixel(1'b1, 1'b0, 4'd1, 6'd0, 5'd0);
    @(negedge Clk);
    idleInputs();
    if (RomAddr !== 15'd1248) begin
      failures++;
      $display("[TB] FAIL transp_romaddr got=%0d exp=1248", RomAddr);
    end
    checks++;
    repeat (2) @(negedge Clk);
    if (CarVisible !== 1'b0 || CarRgb !== 12'h000) begin
      failures++;
      $display("[TB] FAIL transp_pixel got vis=%b rgb=%h exp vis=0 rgb=000", CarVisible, CarRgb);
    end
    checks++;

    // X=50 is outside the sprite; address 0 holds an opaque index on purpose.
    setPixel(1'b1, 1'b0, 4'd2, 6'd50, 5'd4);
    @(negedge Clk);
    idleInputs();
    if (RomAddr !== 15'd0) begin
      failures++;
      $display("[TB] FAIL xrange_romaddr got=%0d exp=0", RomAddr);
    end
    checks++;
    repeat (2) @(negedge Clk);
    if (CarVisible !== 1'b0 || CarRgb !== 12'h000) begin
      failures++;
      $display("[TB] FAIL xrange_pixel got vis=%b rgb=%h exp vis=0 rgb=000", CarVisible, CarRgb);
    end
    checks++;

    // Y=26 is one row past the bottom edge.
    setPixel(1'b1, 1'b0, 4'd0, 6'd0, 5'd26);
    @(negedge Clk);
    idleInputs();
    if (RomAddr !== 15'd0) begin
      failures++;
      $display("[TB] FAIL yrange_romaddr got=%0d exp=0", RomAddr);
    end
    checks++;
    repeat (2) @(negedge Clk);
    if (CarVisible !== 1'b0) begin
      failures++;
      $display("[TB] FAIL yrange_pixel got vis=%b exp vis=0", CarVisible);
    end
    checks++;

    // Tile 15, X=47, Y=25 -> 18720 + 1200 + 47 = 19967.
    setPixel(1'b1, 1'b0, 4'd15, 6'd47, 5'd25);
    @(negedge Clk);
    idleInputs();
    if (RomAddr !== 15'd19967) begin
      failures++;
      $display("[TB] FAIL maxaddr_romaddr got=%0d exp=19967", RomAddr);
    end
    checks++;
    repeat (2) @(negedge Clk);
    if (CarVisible !== 1'b1 || CarRgb !== 12'hF80) begin
      failures++;
      $display("[TB] FAIL maxaddr_pixel got vis=%b rgb=%h exp vis=1 rgb=F80", CarVisible, CarRgb);
    end
    checks++;
  endtask

  // Address 3*1248 + 2*48 + 10 = 3850 holds index 5; three overlap pixels.
  task automatic test_hit();
    setPixel(1'b1, 1'b1, 4'd3, 6'd10, 5'd2);
    repeat (2) @(negedge Clk);
    if (Hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hit_early got=%b exp=0", Hit);
    end
    checks++;
    @(negedge Clk);
    idleInputs();
    if (Hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hit_set got=%b exp=1", Hit);
    end
    checks++;
    @(negedge Clk);
    HitAck = 1'b1;
    @(negedge Clk);
    if (Hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hit_ack_vs_overlap got=%b exp=1", Hit);
    end
    checks++;
    @(negedge Clk);
    HitAck = 1'b0;
    if (Hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hit_cleared got=%b exp=0", Hit);
    end
    checks++;
  endtask

  // Counter snapshot, saturation, clearing and the coincident frame edge.
  task automatic test_overlap_counter();
    FrameStart = 1'b1;
    @(negedge Clk);
    FrameStart = 1'b0;
    if (LastOverlap !== 8'd3) begin
      failures++;
      $display("[TB] FAIL ovl_three got=%0d exp=3", LastOverlap);
    end
    checks++;

    setPixel(1'b1, 1'b1, 4'd3, 6'd10, 5'd2);
    repeat (300) @(negedge Clk);
    idleInputs();
    repeat (3) @(negedge Clk);
    FrameStart = 1'b1;
    @(negedge Clk);
    FrameStart = 1'b0;
    if (LastOverlap !== 8'd255) begin
      failures++;
      $display("[TB] FAIL ovl_saturate got=%0d exp=255", LastOverlap);
    end
    checks++;
    FrameStart = 1'b1;
    @(negedge Clk);
    FrameStart = 1'b0;
    if (LastOverlap !== 8'd0) begin
      failures++;
      $display("[TB] FAIL ovl_cleared got=%0d exp=0", LastOverlap);
    end
    checks++;

    // Overlaps land on edges 3,4,5; FrameStart on edge 5 takes the third.
    setPixel(1'b1, 1'b1, 4'd3, 6'd10, 5'd2);
    repeat (3) @(negedge Clk);
    idleInputs();
    @(negedge Clk);
    FrameStart = 1'b1;
    @(negedge Clk);
    FrameStart = 1'b0;
    if (LastOverlap !== 8'd2) begin
      failures++;
      $display("[TB] FAIL ovl_coincident_snap got=%0d exp=2", LastOverlap);
    end
    checks++;
    @(negedge Clk);
    FrameStart = 1'b1;
    @(negedge Clk);
    FrameStart = 1'b0;
    if (LastOverlap !== 8'd1) begin
      failures++;
      $display("[TB] FAIL ovl_coincident_seed got=%0d exp=1", LastOverlap);
    end
    checks++;
  endtask

  // Address 4*1248 = 4992 holds index 7. Two pixels; pal[7] is rewritten on
  // the edge where the first one reads it.
  task automatic test_palette_collision();
    writePal(4'd7, 12'h123);
    setPixel(1'b1, 1'b0, 4'd4, 6'd0, 5'd0);
    repeat (2) @(negedge Clk);
    idleInputs();
    PalWe  = 1'b1;
    PalIdx = 4'd7;
    PalRgb = 12'hABC;
    @(negedge Clk);
    PalWe  = 1'b0;
    if (CarVisible !== 1'b1 || CarRgb !== 12'h123) begin
      failures++;
      $display("[TB] FAIL pal_old_colour got vis=%b rgb=%h exp vis=1 rgb=123", CarVisible, CarRgb);
    end
    checks++;
    @(negedge Clk);
    if (CarVisible !== 1'b1 || CarRgb !== 12'hABC) begin
      failures++;
      $display("[TB] FAIL pal_new_colour got vis=%b rgb=%h exp vis=1 rgb=ABC", CarVisible, CarRgb);
    end
    checks++;
    @(negedge Clk);
  endtask

  // Asynchronous reset with pixels streaming, then the refill latency.
  task automatic test_reset_midflight();
    setPixel(1'b1, 1'b1, 4'd2, 6'd3, 5'd4);
    repeat (3) @(negedge Clk);
    if (CarVisible !== 1'b1 || Hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_before got vis=%b hit=%b exp vis=1 hit=1", CarVisible, Hit);
    end
    checks++;
    #2;
    ResetN = 1'b0;
    #1;
    if (CarVisible !== 1'b0 || CarRgb !== 12'h000 || Hit !== 1'b0 ||
        LastOverlap !== 8'd0 || RomAddr !== 15'd0) begin
      failures++;
      $display("[TB] FAIL midrst_async got vis=%b rgb=%h hit=%b last=%0d addr=%0d exp all 0",
               CarVisible, CarRgb, Hit, LastOverlap, RomAddr);
    end
    checks++;
    @(negedge Clk);
    ResetN = 1'b1;
    PlayerPixel = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge Clk);
      if (CarVisible !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrst_refill_%0d got vis=%b exp vis=0", k, CarVisible);
      end
      checks++;
    end
    @(negedge Clk);
    // Palette was cleared by reset, so the opaque texel shows as black.
    if (CarVisible !== 1'b1 || CarRgb !== 12'h000) begin
      failures++;
      $display("[TB] FAIL midrst_first got vis=%b rgb=%h exp vis=1 rgb=000", CarVisible, CarRgb);
    end
    checks++;
    idleInputs();
    @(negedge Clk);
  endtask

  // Runs every scenario in order and prints the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    for (int a = 0; a < 32768; a++) begin
      romMem[a] = 4'd0;
    end
    romMem[0]     = 4'd5;
    romMem[2691]  = 4'd5;
    romMem[3850]  = 4'd5;
    romMem[4992]  = 4'd7;
    romMem[19967] = 4'd5;

    test_reset();
    test_basic_pixel();
    test_range_and_transparency();
    test_hit();
    test_overlap_counter();
    test_palette_collision();
    test_reset_midflight();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
